mapper_mem_bridge: RTL
======================

MAPPER_MEM_BRIDGE -- requirements
Module: mapper_mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles in REQ awaiting mem_ack before abort (range 1..255).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  bus-sample qualifier; new bus accesses are recognised only when high.
REQ-005 SHALL have port bus_addr  input  23  mapped memory address from the memory mapper.
REQ-006 SHALL have port cart_ena  input  1  mapper's slot-selected memory-cycle indication.
REQ-007 SHALL have ports rd_n, wr_n  input  1 each  Z80 strobes, active-low.
REQ-008 SHALL have port cdin  input  8  Z80 write data.
REQ-009 SHALL have ports cdout  output 8 (read data) and busreq  output 1 (bridge drives Z80 data bus).
REQ-010 SHALL have ports mem_req  output 1, mem_we  output 1, mem_addr  output 23, mem_wdata  output 8 (memory controller request side).
REQ-011 SHALL have ports mem_ack  input 1 (one-cycle completion pulse) and mem_rdata  input 8 (valid with mem_ack).
REQ-012 SHALL have ports wait_n  output 1 (Z80 WAIT, active-low) and timeout_err  output 1 (one-cycle abort pulse).

Function
REQ-013 SHALL implement states IDLE, REQ, HOLD.
REQ-014 IDLE->REQ SHALL occur when enable=1, cart_ena=1 and (rd_n=0 or wr_n=0); same edge latches mem_addr<=bus_addr, mem_we<=~wr_n, mem_wdata<=cdin, clears timeout counter.
REQ-015 If rd_n=0 and wr_n=0 together at start, access SHALL be treated as a write.
REQ-016 mem_req SHALL be 1 exactly while in REQ; mem_addr, mem_we, mem_wdata SHALL stay stable while mem_req=1.
REQ-017 mem_ack in REQ SHALL move to HOLD on that edge; for reads cdout<=mem_rdata and busreq<=1 on the same edge (busreq visible one cycle after ack).
REQ-018 mem_ack outside REQ SHALL be ignored.
REQ-019 Timeout counter SHALL increment each REQ cycle without ack (8 bits, saturating); reaching TIMEOUT without ack SHALL force HOLD, cdout<=8'hFF, busreq<=mem_we?0:1, timeout_err=1 for one cycle.
REQ-020 Ack and timeout on the same cycle SHALL resolve as ack (no error, real data).
REQ-021 HOLD->IDLE SHALL occur when cart_ena=0 or (rd_n=1 and wr_n=1), independent of enable; busreq<=0 on that edge.
REQ-022 No second access SHALL start until HOLD is exited, i.e. one memory request per Z80 bus cycle.
REQ-023 busreq SHALL never be 1 for a write access.
REQ-024 cdout SHALL hold its last value in IDLE.

Reset
REQ-025 reset=1 SHALL on the next edge force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cdout=8'hFF, busreq=0, timeout_err=0, wait_n=1, counter=0.
REQ-026 Reset during REQ SHALL abandon the request without timeout_err; a following mem_ack SHALL be ignored.

Configuration
REQ-027 Macro MEMBRIDGE_WAIT_EN defined: wait_n SHALL be 0 combinationally when state=REQ, or when IDLE start condition of REQ-014 is true, else 1.
REQ-028 Macro MEMBRIDGE_WAIT_EN undefined: wait_n SHALL be constant 1; all other behaviour unchanged.

Verification
REQ-029 Read: bus_addr=23'h020123, cart_ena=1, rd_n=0, enable=1; mem_ack after 3 cycles with mem_rdata=8'h5A -> mem_req high 3 cycles, mem_we=0, cdout=8'h5A, busreq=1 until rd_n=1, then 0.
REQ-030 Write: bus_addr=23'h03C000, cdin=8'hA7, wr_n=0; ack after 1 cycle -> mem_we=1, mem_wdata=8'hA7, busreq stays 0.
REQ-031 Timeout: TIMEOUT=4, read, no ack -> mem_req high 4 cycles, timeout_err single pulse, cdout=8'hFF, busreq=1.
REQ-032 Reset mid-REQ: assert reset 2 cycles into REQ, then pulse mem_ack -> mem_req=0 next edge, no busreq, no timeout_err, cdout=8'hFF.
REQ-033 Held strobe: rd_n held low 10 cycles after ack -> exactly one mem_req pulse train; release then re-assert -> second request issued.
REQ-034 With MEMBRIDGE_WAIT_EN: wait_n low from start cycle through last REQ cycle, high after ack; without macro wait_n constantly 1.

Source files
------------

// File: rtl/mapper_mem_bridge.sv
// Bridges mapper-decoded Z80 memory cycles onto a req/ack memory controller, one request per bus cycle.
// Optional Z80 WAIT generation is built in when MEMBRIDGE_WAIT_EN is defined.
module mapper_mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [22:0] bus_addr,
  input  logic        cart_ena,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  cdin,
  output logic [7:0]  cdout,
  output logic        busreq,
  output logic        mem_req,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        wait_n,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_r;
  logic [7:0] tmo_cnt_r;
  logic       strobe_s;
  logic       start_s;
  logic       expire_s;

  // Start and expiry decode
  always_comb begin
    strobe_s = ~rd_n | ~wr_n;
    expire_s = (tmo_cnt_r >= TMO_LAST);
    if (state_r == ST_IDLE) begin
      start_s = enable & cart_ena & strobe_s;
    end else begin
      start_s = 1'b0;
    end
  end

  // Access sequencer with registered memory-side and Z80-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      tmo_cnt_r   <= 8'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 23'd0;
      mem_wdata   <= 8'd0;
      cdout       <= 8'hFF;
      busreq      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r   <= ST_REQ;
            mem_req   <= 1'b1;
            mem_we    <= ~wr_n;
            mem_addr  <= bus_addr;
            mem_wdata <= cdin;
            tmo_cnt_r <= 8'd0;
          end
        end
        ST_REQ: begin
          // An ack on the expiry cycle wins: real data, no error
          if (mem_ack) begin
            state_r <= ST_HOLD;
            mem_req <= 1'b0;
            if (!mem_we) begin
              cdout  <= mem_rdata;
              busreq <= 1'b1;
            end
          end else begin
            if (tmo_cnt_r != 8'hFF) begin
              tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end
            if (expire_s) begin
              state_r     <= ST_HOLD;
              mem_req     <= 1'b0;
              cdout       <= 8'hFF;
              busreq      <= ~mem_we;
              timeout_err <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!cart_ena || !strobe_s) begin
            state_r <= ST_IDLE;
            busreq  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mem_req <= 1'b0;
          busreq  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEMBRIDGE_WAIT_EN
  assign wait_n = ~((state_r == ST_REQ) | start_s);
`else
  assign wait_n = 1'b1;
`endif

endmodule
